// File: rtl/ddr_channel_arb_n.sv
// N-channel request arbiter in front of a single-port DDR model: one command in flight,
// completion routed to the owner, per-channel flush. Define DDR_ARB_ROUND_ROBIN_EN for round-robin.
module ddr_channel_arb_n #(
  parameter int NUM_CH  = 3,
  parameter int IDX_W   = 19,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = 64,
  parameter int BURST_W = 512
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*IDX_W-1:0]    req_index,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH-1:0]          req_burst,
  input  logic [NUM_CH*MASK_W-1:0]   req_wmask,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [BURST_W-1:0]         resp_burst_data,
  input  logic [NUM_CH-1:0]          flush,
  output logic                       busy,
  output logic                       ddr_chip_enable,
  output logic [IDX_W-1:0]           ddr_index,
  output logic                       ddr_write_enable,
  output logic                       ddr_burst_mode,
  output logic [MASK_W-1:0]          ddr_write_mask,
  output logic [DATA_W-1:0]          ddr_write_data,
  input  logic [DATA_W-1:0]          ddr_read_data,
  input  logic [BURST_W-1:0]         ddr_burst_read_data,
  input  logic                       ddr_operation_done,
  input  logic                       ddr_ready
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] CH_ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_r, state_n_s;
  logic [NUM_CH-1:0] eligible_s, grant_s, owner_oh_s;
  logic [CH_W-1:0]   win_idx_s, owner_r, scan_base_s;
  logic              found_s, hit_s, accept_s, flush_own_s, drop_r, done_s;

  // Channel reached k steps after base, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] scan_idx(input logic [CH_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    return CH_W'(sum % NUM_CH);
  endfunction

`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] rr_ptr_r;
  assign scan_base_s = rr_ptr_r;

  // Round-robin pointer moves one past the winner on every accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r <= {CH_W{1'b0}};
    end else if (accept_s) begin
      rr_ptr_r <= scan_idx(win_idx_s, 1);
    end
  end
`else
  assign scan_base_s = {CH_W{1'b0}};
`endif

  // First eligible channel in scan order; flushed channels never compete.
  always_comb begin
    eligible_s = req_valid & ~flush;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    win_idx_s  = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      hit_s     = ~found_s & eligible_s[scan_idx(scan_base_s, k)];
      win_idx_s = hit_s ? scan_idx(scan_base_s, k) : win_idx_s;
      found_s   = found_s | hit_s;
    end
  end

  assign accept_s    = (state_r == ST_IDLE) & ddr_ready & found_s & ~reset;
  assign grant_s     = accept_s ? (CH_ONE << win_idx_s) : {NUM_CH{1'b0}};
  assign req_ready   = grant_s;
  assign owner_oh_s  = CH_ONE << owner_r;
  assign flush_own_s = flush[owner_r];
  assign done_s      = (state_r == ST_WAIT) & ddr_operation_done;

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_n_s = ST_ISSUE; else state_n_s = ST_IDLE;
      ST_ISSUE: state_n_s = ST_WAIT;
      ST_WAIT:  if (ddr_operation_done) state_n_s = ST_IDLE; else state_n_s = ST_WAIT;
      default:  state_n_s = ST_IDLE;
    endcase
  end

  // Control state: FSM, busy, drop flag, command strobe and response pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      busy            <= 1'b0;
      drop_r          <= 1'b0;
      owner_r         <= {CH_W{1'b0}};
      ddr_chip_enable <= 1'b0;
      resp_valid      <= {NUM_CH{1'b0}};
    end else begin
      state_r         <= state_n_s;
      busy            <= (state_n_s != ST_IDLE);
      ddr_chip_enable <= accept_s;
      if (accept_s) owner_r <= win_idx_s;
      if (state_n_s == ST_IDLE) drop_r <= 1'b0;
      else if ((state_r != ST_IDLE) && flush_own_s) drop_r <= 1'b1;
      // A flush landing together with done still suppresses the response.
      resp_valid <= (done_s && !(drop_r || flush_own_s)) ? owner_oh_s : {NUM_CH{1'b0}};
    end
  end

  // Datapath: command fields latched at accept, read data captured at done.
  always_ff @(posedge clock) begin
    if (reset) begin
      ddr_index        <= {IDX_W{1'b0}};
      ddr_write_enable <= 1'b0;
      ddr_burst_mode   <= 1'b0;
      ddr_write_mask   <= {MASK_W{1'b0}};
      ddr_write_data   <= {DATA_W{1'b0}};
      resp_data        <= {DATA_W{1'b0}};
      resp_burst_data  <= {BURST_W{1'b0}};
    end else begin
      if (accept_s) begin
        ddr_index        <= req_index[win_idx_s*IDX_W +: IDX_W];
        ddr_write_enable <= req_write[win_idx_s];
        ddr_burst_mode   <= req_burst[win_idx_s] & ~req_write[win_idx_s];
        ddr_write_mask   <= req_wmask[win_idx_s*MASK_W +: MASK_W];
        ddr_write_data   <= req_wdata[win_idx_s*DATA_W +: DATA_W];
      end
      if (done_s) begin
        resp_data       <= ddr_read_data;
        resp_burst_data <= ddr_burst_read_data;
      end
    end
  end

endmodule

// File: tb/tb_ddr_channel_arb_n.sv
// Self-checking bench for ddr_channel_arb_n: directed operations, response scoreboard.
module tb_ddr_channel_arb_n;
  localparam int NUM_CH = 3, IDX_W = 19, DATA_W = 64, MASK_W = 64, BURST_W = 512;

  logic clock = 1'b0, reset;
  logic [NUM_CH-1:0] req_valid, req_ready, req_write, req_burst, resp_valid, flush;
  logic [NUM_CH*IDX_W-1:0] req_index;
  logic [NUM_CH*MASK_W-1:0] req_wmask;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] resp_data, ddr_write_data, ddr_read_data;
  logic [BURST_W-1:0] resp_burst_data, ddr_burst_read_data;
  logic busy, ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_operation_done, ddr_ready;
  logic [IDX_W-1:0] ddr_index;
  logic [MASK_W-1:0] ddr_write_mask;

  ddr_channel_arb_n #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .BURST_W(BURST_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_write(req_write), .req_burst(req_burst),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_burst_data(resp_burst_data), .flush(flush), .busy(busy),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index), .ddr_write_enable(ddr_write_enable),
    .ddr_burst_mode(ddr_burst_mode), .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
    .ddr_read_data(ddr_read_data), .ddr_burst_read_data(ddr_burst_read_data),
    .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready));

  always #5 clock = ~clock;

  int total_cnt = 0;
  int bad_cnt = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [NUM_CH-1:0]  ch;
    logic               is_read;
    logic               is_burst;
    logic [DATA_W-1:0]  data;
    logic [BURST_W-1:0] bdata;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [BURST_W-1:0] obs, input logic [BURST_W-1:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clock) begin
    if (mon_en && (resp_valid !== '0)) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_resp", resp_valid, '0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("resp_owner", resp_valid, mon_e.ch);
        if (mon_e.is_read && mon_e.is_burst) check_val("resp_burst", resp_burst_data, mon_e.bdata);
        else if (mon_e.is_read) check_val("resp_data", resp_data, mon_e.data);
      end
    end
  end

  task automatic run_op(input logic [NUM_CH-1:0] valids, input int win, input logic [IDX_W-1:0] idx,
                        input logic wr, input logic bu, input logic [MASK_W-1:0] m,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                        input logic [BURST_W-1:0] bd, input int wait_cyc,
                        input logic [NUM_CH-1:0] fmask, input string tag);
    logic [NUM_CH-1:0] oh;
    exp_t e;
    oh = '0;
    oh[win] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      req_index[c*IDX_W +: IDX_W] = IDX_W'(19'h1111 * (c + 1) + 19'h7);
      req_write[c] = 1'b0;
      req_burst[c] = 1'b0;
      req_wmask[c*MASK_W +: MASK_W] = 64'hA5A5_0000_0000_0000 | MASK_W'(c);
      req_wdata[c*DATA_W +: DATA_W] = 64'h5A5A_0000_0000_0000 | DATA_W'(c);
    end
    req_index[win*IDX_W +: IDX_W] = idx;
    req_write[win] = wr;
    req_burst[win] = bu;
    req_wmask[win*MASK_W +: MASK_W] = m;
    req_wdata[win*DATA_W +: DATA_W] = wd;
    req_valid = valids;
    #1;
    check_val({tag, "_ready"}, req_ready, oh);
    tick();
    check_val({tag, "_ce"}, ddr_chip_enable, 1'b1);
    check_val({tag, "_idx"}, ddr_index, idx);
    check_val({tag, "_we"}, ddr_write_enable, wr);
    check_val({tag, "_bm"}, ddr_burst_mode, bu & ~wr);
    if (wr) begin
      check_val({tag, "_mask"}, ddr_write_mask, m);
      check_val({tag, "_wdata"}, ddr_write_data, wd);
    end
    check_val({tag, "_busy"}, busy, 1'b1);
    check_val({tag, "_ready_busy"}, req_ready, '0);
    tick();
    check_val({tag, "_ce_off"}, ddr_chip_enable, 1'b0);
    check_val({tag, "_idx_hold"}, ddr_index, idx);
    if (fmask != '0) begin
      flush = fmask;
      tick();
      flush = '0;
    end
    repeat (wait_cyc) tick();
    ddr_operation_done = 1'b1;
    ddr_read_data = rd;
    ddr_burst_read_data = bd;
    if (!fmask[win]) begin
      e.ch = oh; e.is_read = ~wr; e.is_burst = bu & ~wr; e.data = rd; e.bdata = bd;
      sb_q.push_back(e);
    end
    tick();
    ddr_operation_done = 1'b0;
    ddr_read_data = 64'h0BAD_0BAD_0BAD_0BAD;
    ddr_burst_read_data = {8{64'hFEED_FACE_0BAD_F00D}};
    check_val({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_index = '0; req_write = '0; req_burst = '0;
    req_wmask = '0; req_wdata = '0; flush = '0; ddr_read_data = '0; ddr_burst_read_data = '0;
    ddr_operation_done = 1'b0; ddr_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ce", ddr_chip_enable, 1'b0);
    check_val("rst_idx", ddr_index, '0);
    check_val("rst_ctl", {ddr_write_enable, ddr_burst_mode}, '0);
    check_val("rst_wm", ddr_write_mask, '0);
    check_val("rst_resp", resp_valid, '0);
    check_val("rst_ready", req_ready, '0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Contention: all three channels valid on every accept.
    for (int i = 0; i < 4; i++) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
      run_op(3'b111, i % 3, IDX_W'(19'h00400 + i), 1'b0, 1'b0, '0, '0, 64'h100 + DATA_W'(i), '0, 0, '0, "cont");
`else
      run_op(3'b111, 0, IDX_W'(19'h00400 + i), 1'b0, 1'b0, '0, '0, 64'h100 + DATA_W'(i), '0, 0, '0, "cont");
`endif
    end

    run_op(3'b010, 1, 19'h00123, 1'b0, 1'b0, '0, '0, 64'hDEAD_BEEF, '0, 2, '0, "load");
    run_op(3'b100, 2, 19'h00777, 1'b1, 1'b1, 64'hFF, 64'h1122_3344_5566_7788, 64'h9999, '0, 0, '0, "store");
    run_op(3'b001, 0, 19'h00ABC, 1'b0, 1'b1, '0, '0, '0, {8{64'hCAFE_0001_0002_0003}}, 1, 3'b001, "flushed");
    run_op(3'b001, 0, 19'h00ABD, 1'b0, 1'b1, '0, '0, '0, {4{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}}, 0, '0, "burst");
    run_op(3'b010, 1, 19'h7FFFF, 1'b0, 1'b0, '0, '0, 64'hFFFF_0000_FFFF_0000, '0, 0, 3'b100, "nonowner_flush");

    // DDR not ready: nothing may be granted or issued.
    req_valid = 3'b111;
    ddr_ready = 1'b0;
    #1;
    check_val("nready_ready", req_ready, '0);
    tick();
    check_val("nready_ce", ddr_chip_enable, 1'b0);
    check_val("nready_busy", busy, 1'b0);
    ddr_ready = 1'b1;
    req_valid = 3'b001;
    flush = 3'b001;
    #1;
    check_val("flushed_no_win", req_ready, '0);
    req_valid = 3'b011;
    #1;
    check_val("flushed_skip", req_ready, 3'b010);
    req_valid = '0;
    flush = '0;

    // Spurious done while idle.
    ddr_operation_done = 1'b1;
    tick();
    ddr_operation_done = 1'b0;
    tick();
    check_val("spur_busy", busy, 1'b0);

    // Reset while waiting for completion, then a late done.
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    tick();
    check_val("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_ce", ddr_chip_enable, 1'b0);
    check_val("midrst_idx", ddr_index, '0);
    check_val("midrst_rdata", resp_data, '0);
    check_val("midrst_bdata", resp_burst_data, '0);
    reset = 1'b0;
    ddr_operation_done = 1'b1;
    tick();
    ddr_operation_done = 1'b0;
    tick();
    check_val("late_done_busy", busy, 1'b0);
    check_val("sb_empty", sb_q.size(), '0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/ddr_channel_arb_n.md
Name: ddr_channel_arb_n

Overview:
- Parametrised N-channel arbiter between the core's memory clients (fetch, load, store, future ports) and the single-port sim DDR model.
- Arbitrates requests, latches the winner, and issues exactly one single-cycle DDR command.
- Tracks the one outstanding operation and routes completion and read data only to the owning channel.
- Supports per-channel flush so a redirected fetch drops its in-flight response cleanly. No forced-handshake hacks are needed.

Parameters:
- NUM_CH, 3: number of request channels, 2..8; channel 0 has highest fixed priority.
- IDX_W, 19: DDR index width.
- DATA_W, 64: single-beat read/write data width.
- MASK_W, 64: write mask width.
- BURST_W, 512: burst read data width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel ready; one-hot or zero.
- req_index  in  NUM_CH*IDX_W  packed indexes; channel i at bits [i*IDX_W +: IDX_W].
- req_write  in  NUM_CH  1 = write.
- req_burst  in  NUM_CH  1 = burst read; ignored when req_write=1.
- req_wmask  in  NUM_CH*MASK_W  packed write masks.
- req_wdata  in  NUM_CH*DATA_W  packed write data.
- resp_valid  out  NUM_CH  one-cycle completion pulse to owner.
- resp_data  out  DATA_W  single-beat read data, valid with resp_valid.
- resp_burst_data  out  BURST_W  burst read data, valid with resp_valid.
- flush  in  NUM_CH  per-channel flush (redirect).
- busy  out  1  an operation is accepted and not yet responded.
- ddr_chip_enable  out  1  one-cycle command strobe.
- ddr_index  out  IDX_W  command index.
- ddr_write_enable  out  1  command is a write.
- ddr_burst_mode  out  1  command is a burst read.
- ddr_write_mask  out  MASK_W  write mask.
- ddr_write_data  out  DATA_W  write data.
- ddr_read_data  in  DATA_W  read data.
- ddr_burst_read_data  in  BURST_W  burst read data.
- ddr_operation_done  in  1  DDR completion pulse.
- ddr_ready  in  1  DDR can accept a command.

Behaviour:
- Reset: state IDLE; all outputs 0, including every ddr_* output, req_ready, resp_valid, resp data and busy; owner and drop flag cleared; RR pointer 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - req_ready is combinational: one-hot on the winning channel among req_valid & ~flush, only when ddr_ready=1.
  - Accept occurs on valid&ready in cycle T.
  - At accept, latch owner, index, write, burst (forced 0 when write), mask and data; go to ISSUE.
- ISSUE (cycle T+1):
  - Registered ddr_chip_enable=1 with the latched fields for exactly one cycle; go to WAIT.
  - ddr_* data and control outputs hold their latched values until the next accept.
- WAIT:
  - On ddr_operation_done in cycle D: resp_valid[owner]=1 in D+1 (registered), unless drop is set.
  - resp_data / resp_burst_data are captured from the DDR inputs at D and held until the next done.
  - Return to IDLE at D+1; a new accept is allowed in D+1.
- Latency: accept-to-command 1 cycle; done-to-response 1 cycle; minimum accept-to-accept 3 cycles.
- ddr_operation_done outside WAIT is ignored.
- flush:
  - flush[owner]=1 in ISSUE or WAIT sets drop. The command still completes (DDR cannot be aborted), but no resp_valid is produced for that operation. drop clears on return to IDLE.
  - A flushed channel cannot win in IDLE that cycle.
  - Flush of a non-owner channel has no effect on the current operation.
- busy = (state != IDLE), registered.
- Write responses pulse resp_valid; resp_data content is don't-care for writes.
- Simultaneous valids: fixed priority, lowest index wins (default).
- Reset mid-operation: immediate return to reset values; a late ddr_operation_done is then ignored (state is IDLE).

Optional Feature:
- Macro: DDR_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at the RR pointer. On accept, the pointer becomes (winner+1) mod NUM_CH. Flushed channels are skipped.
- Undefined: fixed priority as above. The pointer register is not instantiated.

Test Plan:
- Single load: ch1 valid, index 0x00123, ddr_ready=1 -> req_ready=3'b010 same cycle; chip_enable at T+1 with index 0x00123, write_enable=0, burst_mode=0; done at T+4 with read data 0xDEAD_BEEF -> resp_valid=3'b010 at T+5, resp_data=0xDEADBEEF.
- Contention, fixed priority: ch0/1/2 valid continuously -> ch0 granted every accept, and ch1/2 never granted while ch0 is valid. With DDR_ARB_ROUND_ROBIN_EN: grant order 0,1,2,0.
- Store: ch2 write, mask 0xFF, data 0x1122334455667788 -> one-cycle chip_enable with write_enable=1, burst_mode=0, ddr_write_mask=0xFF, ddr_write_data=0x1122334455667788; req_burst=1 is ignored.
- Flush in flight: ch0 burst read accepted, flush[0] pulsed in WAIT -> done consumed, no resp_valid, busy drops, the next request accepted normally.
- ddr_ready=0 with req_valid=3'b111 -> req_ready=0, no chip_enable. A spurious ddr_operation_done in IDLE -> no resp_valid.
- Reset asserted in WAIT -> all outputs 0 next cycle; a done arriving afterwards produces no response.
